// File: rtl/mem_access_unit_if.sv
// Data-memory bus of mem_access_unit: the unit drives the master side, the memory the slave side.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_wmask;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: valid/ready memory transactions, store lane steering, load extension.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_valid,
    output logic                  misalign,
    mem_access_unit_if.master     mem
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                state;
    logic [1:0]            off_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic                  done;
    logic                  capture;
    logic [1:0]            off_n;
    logic [3:0]            wmask_n;
    logic [DATA_WIDTH-1:0] wdata_n;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] ext;

    assign done    = (state == S_REQ && mem.mem_req_ready && mem.mem_we) ||
                     (state == S_WAIT && mem.mem_resp_valid);
    assign capture = req_valid && (state == S_IDLE || done);
    assign stall   = (state == S_REQ || state == S_WAIT) && !done;

    // Offset is force-aligned to the access size; the trap build checks the raw address separately.
    always_comb begin
        off_n   = req_addr[1:0];
        wmask_n = 4'b1111;
        wdata_n = req_wdata;
        case (req_size)
            2'b00: begin
                wmask_n = 4'b0001 << off_n;
                wdata_n = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                off_n   = {req_addr[1], 1'b0};
                wmask_n = 4'b0011 << off_n;
                wdata_n = {2{req_wdata[15:0]}};
            end
            default: off_n = 2'b00;
        endcase
        if (!req_we) wmask_n = '0;
    end

    always_comb begin
        word = mem.mem_resp_data >> {off_q, 3'b000};
        case (size_q)
            2'b00:   ext = {{24{!uns_q && word[7]}}, word[7:0]};
            2'b01:   ext = {{16{!uns_q && word[15]}}, word[15:0]};
            default: ext = word;
        endcase
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic bad;
    assign bad = (req_size == 2'b01) ? req_addr[0] :
                 (req_size[1] ? |req_addr[1:0] : 1'b0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) misalign <= 1'b0;
        else       misalign <= capture && bad;
    end
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            off_q             <= '0;
            size_q            <= '0;
            uns_q             <= 1'b0;
            ld_data           <= '0;
            ld_valid          <= 1'b0;
            mem.mem_req_valid <= 1'b0;
            mem.mem_we        <= 1'b0;
            mem.mem_addr      <= '0;
            mem.mem_wdata     <= '0;
            mem.mem_wmask     <= '0;
        end else begin
            ld_valid <= 1'b0;
            if (state == S_WAIT && mem.mem_resp_valid) begin
                ld_data  <= ext;
                ld_valid <= 1'b1;
            end
            if (capture) begin
                off_q             <= off_n;
                size_q            <= req_size;
                uns_q             <= req_unsigned;
                mem.mem_we        <= req_we;
                mem.mem_addr      <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                mem.mem_wdata     <= wdata_n;
                mem.mem_wmask     <= wmask_n;
                mem.mem_req_valid <= 1'b1;
                state             <= S_REQ;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                if (bad) begin
                    mem.mem_req_valid <= 1'b0;
                    state             <= S_IDLE;
                end
`endif
            end else if (done) begin
                mem.mem_req_valid <= 1'b0;
                state             <= S_IDLE;
            end else if (state == S_REQ && mem.mem_req_ready) begin
                mem.mem_req_valid <= 1'b0;
                state             <= S_WAIT;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random load/store traffic against a transaction-level model.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        stall, ld_valid, misalign;
    logic [31:0] ld_data;

    mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif ();

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .stall(stall), .ld_data(ld_data),
        .ld_valid(ld_valid), .misalign(misalign), .mem(mif)
    );

    always #5 clk = ~clk;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int unsigned n_checks = 0, n_pass = 0;

    // model: at most one in-flight transaction, plus memory behaviour knobs
    bit          have, acc, exp_ldv, exp_mis, force_resp, captured;
    logic        t_we, t_uns;
    logic [1:0]  t_size;
    logic [31:0] t_addr, t_wdata, rsp_word, exp_ldd;
    int unsigned rdy_wait, rsp_wait, nxt_rdy, nxt_rsp;
    logic [31:0] nxt_word;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_mask;
    logic        snap_stall;
    int unsigned ldv_cnt, stall_cnt, mis_cnt, reqv_cnt;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int unsigned nbytes(logic [1:0] s);
        return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    endfunction

    function automatic int unsigned lane0(logic [31:0] a, logic [1:0] s);
        int unsigned n, lo;
        n  = nbytes(s);
        lo = 32'(a[1:0]);
        return (lo / n) * n;
    endfunction

    function automatic bit misaligned(logic [31:0] a, logic [1:0] s);
        int unsigned lo;
        lo = 32'(a[1:0]);
        return (lo % nbytes(s)) != 0;
    endfunction

    function automatic logic [3:0] exp_mask(logic we, logic [31:0] a, logic [1:0] s);
        int unsigned n, b;
        logic [3:0] m;
        n = nbytes(s);
        b = lane0(a, s);
        m = '0;
        for (int unsigned i = 0; i < 4; i++)
            if (we && i >= b && i < b + n) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_wdata(logic [31:0] d, logic [1:0] s);
        int unsigned n;
        logic [31:0] r;
        n = nbytes(s);
        for (int unsigned i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(logic [31:0] w, logic [31:0] a, logic [1:0] s, logic u);
        int unsigned n, b;
        logic [31:0] r;
        logic [7:0]  top;
        n = nbytes(s);
        b = lane0(a, s);
        r = '0;
        for (int unsigned k = 0; k < n; k++) r[8*k +: 8] = w[8*(b+k) +: 8];
        top = r[8*(n-1) +: 8];
        for (int unsigned k = n; k < 4; k++) r[8*k +: 8] = (!u && top[7]) ? 8'hFF : 8'h00;
        return r;
    endfunction

    task automatic model_reset();
        have = 0; acc = 0; exp_ldv = 0; exp_mis = 0; exp_ldd = '0;
    endtask

    task automatic clear_counts();
        ldv_cnt = 0; stall_cnt = 0; mis_cnt = 0; reqv_cnt = 0;
    endtask

    // One clock: drive memory side at posedge+1, compare at negedge, advance model to next edge.
    task automatic cycle();
        bit done, cap;
        if (have && !acc) mif.mem_req_ready = (rdy_wait == 0);
        else              mif.mem_req_ready = 1'($urandom_range(0, 1));
        if (have && acc) begin
            mif.mem_resp_valid = (rsp_wait == 0);
            mif.mem_resp_data  = (rsp_wait == 0) ? rsp_word : $urandom;
        end else begin
            mif.mem_resp_valid = force_resp || ($urandom_range(0, 3) == 0);
            mif.mem_resp_data  = $urandom;
        end
        @(negedge clk);
        chk("mem_req_valid", 32'(mif.mem_req_valid), 32'(have && !acc));
        if (have && !acc) begin
            chk("mem_we", 32'(mif.mem_we), 32'(t_we));
            chk("mem_addr", mif.mem_addr, t_addr & 32'hFFFF_FFFC);
            chk("mem_wmask", 32'(mif.mem_wmask), 32'(exp_mask(t_we, t_addr, t_size)));
            if (t_we) chk("mem_wdata", mif.mem_wdata, exp_wdata(t_wdata, t_size));
        end
        done = have && ((!acc && mif.mem_req_ready && t_we) || (acc && mif.mem_resp_valid));
        chk("stall", 32'(stall), 32'(have && !done));
        chk("ld_valid", 32'(ld_valid), 32'(exp_ldv));
        chk("ld_data", ld_data, exp_ldd);
        chk("misalign", 32'(misalign), 32'(exp_mis));
        if (ld_valid) ldv_cnt++;
        if (stall) stall_cnt++;
        if (misalign) mis_cnt++;
        if (mif.mem_req_valid) reqv_cnt++;
        if (mif.mem_req_valid && mif.mem_req_ready) begin
            snap_addr = mif.mem_addr; snap_mask = mif.mem_wmask;
            snap_wdata = mif.mem_wdata; snap_stall = stall;
        end
        exp_ldv = 0;
        exp_mis = 0;
        if (have && acc && mif.mem_resp_valid) begin
            exp_ldv = 1;
            exp_ldd = exp_load(rsp_word, t_addr, t_size, t_uns);
        end
        cap = req_valid && (!have || done);
        if (done) have = 0;
        else if (have && !acc) begin
            if (mif.mem_req_ready) acc = 1;
            else rdy_wait--;
        end else if (have && acc) rsp_wait--;
        captured = cap;
        if (cap) begin
            if (TRAP && misaligned(req_addr, req_size)) begin
                exp_mis = 1;
                have    = 0;
            end else begin
                have = 1; acc = 0;
                t_we = req_we; t_addr = req_addr; t_wdata = req_wdata;
                t_size = req_size; t_uns = req_unsigned;
                rdy_wait = nxt_rdy; rsp_wait = nxt_rsp; rsp_word = nxt_word;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic u, input int unsigned rdy,
                         input int unsigned rsp, input logic [31:0] w,
                         output int unsigned waited);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        req_size = s; req_unsigned = u;
        nxt_rdy = rdy; nxt_rsp = rsp; nxt_word = w;
        waited = 0;
        captured = 0;
        while (!captured && waited < 64) begin
            cycle();
            waited++;
        end
        chk("captured", 32'(captured), 32'd1);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_unsigned = 1'($urandom);
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (have && n < 64) begin
            cycle();
            n++;
        end
        chk("drained", 32'(have), 32'd0);
        cycle();
    endtask

    task automatic run_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s, input logic u, input int unsigned rdy,
                          input int unsigned rsp, input logic [31:0] w);
        int unsigned wt;
        issue(we, a, d, s, u, rdy, rsp, w, wt);
        drain();
    endtask

    task automatic async_reset();
        #1 reset = 1'b1;
        #1;
        chk("rst_req_valid", 32'(mif.mem_req_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ld_valid", 32'(ld_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned wt;
        logic        r_we, r_u;
        logic [1:0]  r_s;
        logic [31:0] r_a;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = '0; req_unsigned = 1'b0; force_resp = 0;
        mif.mem_req_ready = 1'b0; mif.mem_resp_valid = 1'b0; mif.mem_resp_data = '0;
        model_reset();
        clear_counts();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_ld_valid", 32'(ld_valid), 32'd0);
        chk("reset_ld_data", ld_data, 32'd0);
        chk("reset_misalign", 32'(misalign), 32'd0);
        chk("reset_req_valid", 32'(mif.mem_req_valid), 32'd0);
        chk("reset_mem_we", 32'(mif.mem_we), 32'd0);
        chk("reset_mem_addr", mif.mem_addr, 32'd0);
        chk("reset_mem_wdata", mif.mem_wdata, 32'd0);
        chk("reset_mem_wmask", 32'(mif.mem_wmask), 32'd0);

        // sb to the top byte lane, zero-wait
        run_op(1'b1, 32'h1003, 32'h0000_00AB, 2'd0, 1'b0, 0, 0, 32'h0);
        chk("sb_addr", snap_addr, 32'h1000);
        chk("sb_mask", 32'(snap_mask), 32'h8);
        chk("sb_wdata", snap_wdata, 32'hABAB_ABAB);
        chk("sb_stall", 32'(snap_stall), 32'd0);

        clear_counts();
        run_op(1'b0, 32'h2002, 32'h0, 2'd0, 1'b0, 0, 0, 32'h0080_FF00);
        chk("lb_data", ld_data, 32'hFFFF_FF80);
        chk("lb_ld_valid_count", ldv_cnt, 32'd1);
        run_op(1'b0, 32'h2002, 32'h0, 2'd0, 1'b1, 0, 0, 32'h0080_FF00);
        chk("lbu_data", ld_data, 32'h0000_0080);

        // lh with three cycles of backpressure
        clear_counts();
        run_op(1'b0, 32'h2002, 32'h0, 2'd1, 1'b0, 3, 0, 32'h8001_1234);
        chk("lh_data", ld_data, 32'hFFFF_8001);
        chk("lh_stall_cycles", stall_cnt, 32'd4);
        chk("lh_req_cycles", reqv_cnt, 32'd4);

        // store then load back-to-back, 2-cycle response latency
        clear_counts();
        issue(1'b1, 32'h4000, 32'h1234_5678, 2'd2, 1'b0, 0, 0, 32'h0, wt);
        issue(1'b0, 32'h4004, 32'h0, 2'd2, 1'b0, 0, 2, 32'h5566_7788, wt);
        chk("b2b_no_bubble", wt, 32'd1);
        drain();
        chk("b2b_data", ld_data, 32'h5566_7788);
        chk("b2b_ld_valid_count", ldv_cnt, 32'd1);

        clear_counts();
        run_op(1'b0, 32'h3002, 32'h0, 2'd2, 1'b0, 0, 0, 32'hCAFE_F00D);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        chk("lw_mis_pulses", mis_cnt, 32'd1);
        chk("lw_mis_no_req", reqv_cnt, 32'd0);
        chk("lw_mis_no_ldv", ldv_cnt, 32'd0);
        chk("lw_mis_no_stall", stall_cnt, 32'd0);
`else
        chk("lw_aligned_addr", snap_addr, 32'h3000);
        chk("lw_aligned_data", ld_data, 32'hCAFE_F00D);
`endif

        // reset while the request is still being offered
        issue(1'b0, 32'h5000, 32'h0, 2'd2, 1'b0, 20, 0, 32'h0, wt);
        async_reset();
        cycle();

        // reset while waiting for a response, then a late response
        issue(1'b0, 32'h5004, 32'h0, 2'd2, 1'b0, 0, 20, 32'h0, wt);
        cycle();
        cycle();
        async_reset();
        clear_counts();
        force_resp = 1;
        cycle();
        force_resp = 0;
        cycle();
        chk("late_resp_ld_valid", ldv_cnt, 32'd0);
        chk("late_resp_req_valid", reqv_cnt, 32'd0);
        chk("late_resp_ld_data", ld_data, 32'd0);

        for (int i = 0; i < 300; i++) begin
            r_we = 1'($urandom);
            r_s  = 2'($urandom_range(0, 3));
            r_u  = 1'($urandom);
            r_a  = 32'h8000 + $urandom_range(0, 255);
            issue(r_we, r_a, $urandom, r_s, r_u, $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom, wt);
            repeat ($urandom_range(0, 2)) cycle();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-side partner of the pipeline controller. It receives the load/store request the controller issues at the end of stage X: write-enable, address, store data, and funct3-derived size and signedness. It runs a valid/ready transaction to data memory, generating the byte write mask and lane-replicated store data. It returns aligned, sign- or zero-extended load data to writeback and stalls the M stage while a transaction is outstanding.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; the lane logic is defined for 32 only
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  memory operation present at X→M boundary
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  rs2 store data, low-aligned
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- req_unsigned  in  1  funct3[2]; zero-extend loads when set
- stall  out  1  freeze M stage and everything upstream
- ld_data  out  32  extended load result, registered
- ld_valid  out  1  one-cycle pulse, ld_data valid
- misalign  out  1  one-cycle pulse on a misaligned request (only under the macro)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  store
- mem_addr  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0
- mem_wdata  out  32  lane-replicated store data
- mem_wmask  out  4  byte enables; 0000 for loads
- mem_resp_valid  in  1  load data returned
- mem_resp_data  in  32  full word from memory

## Operation
- States:
  - IDLE: no transaction.
  - REQ: mem_req_valid high.
  - WAIT: load accepted by memory, response pending.
- done = (REQ & mem_req_ready & mem_we) | (WAIT & mem_resp_valid).
- Capture happens when req_valid & (IDLE | done). On capture, all request fields and the offset addr[1:0] are latched into payload registers, and the state goes to REQ.
- Transitions:
  - REQ & ready & store → IDLE, or REQ if a new capture occurs.
  - REQ & ready & load → WAIT.
  - WAIT & resp_valid → IDLE, or REQ on capture.
- Request hold: mem_req_valid and the whole payload are registered and stay stable until mem_req_ready is sampled high. The unit never drops or changes a request before that.
- Store lanes:
  - byte: wmask = 0001 << off; wdata = {4{b}}.
  - half: wmask = 0011 << (2·addr[1]); wdata = {2{h}}.
  - word: wmask = 1111; wdata unchanged.
- Load extraction: w = mem_resp_data >> (8·off).
  - byte: w[7:0], extended from bit 7.
  - half: w[15:0], extended from bit 15.
  - word: w unchanged.
  - Sign extension unless req_unsigned is set.
- stall = (REQ | WAIT) & !done.
- Responses:
  - mem_resp_valid in IDLE or REQ is ignored.
  - mem_resp_valid in the same cycle as the request handshake is not used; a response is taken only in WAIT.

## Timing
- Reset values: state IDLE; stall 0, ld_valid 0, ld_data 0, misalign 0, mem_req_valid 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_wmask 0.
- Reset mid-transaction: mem_req_valid drops asynchronously and the pending load is abandoned. A late mem_resp_valid after reset is ignored.
- Store, zero-wait memory: capture edge E0; REQ during cycle 1 with ready high; stall low in cycle 1; IDLE after E2.
- Load, zero-wait memory: E0 capture; cycle 1 REQ handshake; cycle 2 WAIT with resp_valid; ld_data and ld_valid appear after E3.
- stall is high in cycle 1 and low in cycle 2.
- Back-to-back: a request presented in the done cycle is captured at that edge, with no bubble.
- ld_valid is never high for two consecutive cycles without two separate responses.

## Configuration
- MEM_ACCESS_MISALIGN_TRAP_EN defined:
  - A half-word request with addr[0] = 1, or a word request with addr[1:0] ≠ 0, is captured but not sent to memory.
  - misalign pulses in the cycle after capture; state stays or returns to IDLE.
  - No stall, no ld_valid.
- Undefined:
  - The address is force-aligned: half ignores addr[0]; word ignores addr[1:0].
  - The access proceeds normally.
  - misalign is tied to 0.

## Test plan
- sb, addr 0x1003, wdata 0xAB, ready high → mem_addr 0x1000, wmask 1000, wdata 0xABABABAB, stall low in the handshake cycle.
- lb, addr 0x2002, response 0x0080FF00 → ld_data 0xFFFFFF80 after E3. Same access as lbu → 0x00000080.
- lh, addr 0x2002, mem_req_ready low for 3 cycles → request and payload stable, stall high throughout. Then response 0x8001xxxx → ld_data 0xFFFF8001.
- Store, then load back-to-back with ready high and 2-cycle response latency → the second request is captured in the store's done cycle, with no bubble. Exactly one ld_valid.
- Reset asserted in WAIT, then resp_valid pulsed → mem_req_valid 0 immediately, ld_valid stays 0, state IDLE.
- lw, addr 0x3002: with the macro → misalign pulse, no mem_req_valid. Without the macro → mem_addr 0x3000, full-word result.
